// File: rtl/accel_ctrl.sv
// accel_ctrl: job sequencer for an NxN systolic-array accelerator.
// Walks each job through weight load/write, activation load, array stream
// and accumulate once per weight tile, then output with the post-op and a final clear.
// All controls are registered and decoded from the next state/counter.
// Optional feature: define ACCEL_CTRL_SOFTMAX_EN to enable the softmax post-op;
// without it softmax_en is tied 0 and softmax_req is ignored.

`ifndef ARRAYWIDTH
`define ARRAYWIDTH 8
`endif

module accel_ctrl #(
   parameter int ARRAYWIDTH = `ARRAYWIDTH,
   parameter int ROWW       = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [ROWW-1:0] k_tiles,
   input  logic [ROWW-1:0] act_rows,
   input  logic            relu_req,
   input  logic            softmax_req,
   output logic            input_buffer_load_en,
   output logic            input_buffer_out_en,
   output logic            input_buffer_delay_clear,
   output logic            weight_buffer_load_en,
   output logic            weight_buffer_out_en,
   output logic            write_weight_en,
   output logic            output_buffer_load_en,
   output logic            output_buffer_out_en,
   output logic            output_buffer_load_clear,
   output logic            output_buffer_acc_enable,
   output logic            output_buffer_acc_clear,
   output logic            relu_en,
   output logic            softmax_en,
   output logic            busy,
   output logic            done,
   output logic            cfg_err
);

   // Two extra bits so act_rows + 2N - 1 cannot wrap.
   localparam int CW = ROWW + 2;
   localparam logic [CW-1:0] N_LAST       = CW'(ARRAYWIDTH - 1);
   localparam logic [CW-1:0] STREAM_EXTRA = CW'(2 * ARRAYWIDTH - 2);
   localparam logic [CW-1:0] LOAD_FIRST   = CW'(2 * ARRAYWIDTH - 1);

   typedef enum logic [3:0] {
      IDLE, LOAD_W, WRITE_W, LOAD_A, STREAM, ACC, OUT, CLEAR, DONE
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [ROWW-1:0] tiles_reg, tiles_next;
   logic [ROWW-1:0] rows_reg, rows_next;
   logic            relu_reg, relu_next;
   logic            job_accept, job_reject;
   logic [CW-1:0]   rows_last, stream_last;

`ifdef ACCEL_CTRL_SOFTMAX_EN
   logic            softmax_reg, softmax_next;
`else
   logic            unused_softmax_req;
   assign unused_softmax_req = softmax_req;
`endif

   // Last-cycle markers for row-length phases, from the captured row count.
   assign rows_last   = {2'b00, rows_reg} - CW'(1);
   assign stream_last = {2'b00, rows_reg} + STREAM_EXTRA;

   // Next-state, cycle counter and job capture.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg + CW'(1);
      tiles_next   = tiles_reg;
      rows_next    = rows_reg;
      relu_next    = relu_reg;
`ifdef ACCEL_CTRL_SOFTMAX_EN
      softmax_next = softmax_reg;
`endif
      job_accept   = 1'b0;
      job_reject   = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (start) begin
               if (k_tiles == '0 || act_rows == '0) begin
                  job_reject = 1'b1;
                  state_next = DONE;
               end else begin
                  job_accept = 1'b1;
                  state_next = LOAD_W;
                  tiles_next = k_tiles;
                  rows_next  = act_rows;
                  relu_next  = relu_req;
`ifdef ACCEL_CTRL_SOFTMAX_EN
                  softmax_next = softmax_req;
`endif
               end
            end
         end
         LOAD_W: begin
            if (cnt_reg == N_LAST) begin
               state_next = WRITE_W;
               cnt_next   = '0;
            end
         end
         WRITE_W: begin
            if (cnt_reg == N_LAST) begin
               state_next = LOAD_A;
               cnt_next   = '0;
            end
         end
         LOAD_A: begin
            if (cnt_reg == rows_last) begin
               state_next = STREAM;
               cnt_next   = '0;
            end
         end
         STREAM: begin
            if (cnt_reg == stream_last) begin
               state_next = ACC;
               cnt_next   = '0;
            end
         end
         ACC: begin
            cnt_next   = '0;
            tiles_next = tiles_reg - ROWW'(1);
            state_next = (tiles_reg == ROWW'(1)) ? OUT : LOAD_W;
         end
         OUT: begin
            if (cnt_reg == rows_last) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         CLEAR: begin
            state_next = DONE;
            cnt_next   = '0;
         end
         DONE: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // State registers plus registered control outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg                <= IDLE;
         cnt_reg                  <= '0;
         tiles_reg                <= '0;
         rows_reg                 <= '0;
         relu_reg                 <= 1'b0;
`ifdef ACCEL_CTRL_SOFTMAX_EN
         softmax_reg              <= 1'b0;
`endif
         input_buffer_load_en     <= 1'b0;
         input_buffer_out_en      <= 1'b0;
         input_buffer_delay_clear <= 1'b0;
         weight_buffer_load_en    <= 1'b0;
         weight_buffer_out_en     <= 1'b0;
         write_weight_en          <= 1'b0;
         output_buffer_load_en    <= 1'b0;
         output_buffer_out_en     <= 1'b0;
         output_buffer_load_clear <= 1'b0;
         output_buffer_acc_enable <= 1'b0;
         output_buffer_acc_clear  <= 1'b0;
         relu_en                  <= 1'b0;
         softmax_en               <= 1'b0;
         busy                     <= 1'b0;
         done                     <= 1'b0;
         cfg_err                  <= 1'b0;
      end else begin
         state_reg                <= state_next;
         cnt_reg                  <= cnt_next;
         tiles_reg                <= tiles_next;
         rows_reg                 <= rows_next;
         relu_reg                 <= relu_next;
`ifdef ACCEL_CTRL_SOFTMAX_EN
         softmax_reg              <= softmax_next;
`endif
         input_buffer_load_en     <= (state_next == LOAD_A);
         input_buffer_out_en      <= (state_next == STREAM);
         input_buffer_delay_clear <= (state_next == STREAM) && (cnt_next == stream_last);
         weight_buffer_load_en    <= (state_next == LOAD_W);
         weight_buffer_out_en     <= (state_next == WRITE_W);
         write_weight_en          <= (state_next == WRITE_W);
         output_buffer_load_en    <= (state_next == STREAM) && (cnt_next >= LOAD_FIRST);
         output_buffer_out_en     <= (state_next == OUT);
         output_buffer_load_clear <= (state_next == ACC);
         output_buffer_acc_enable <= (state_next == ACC);
         output_buffer_acc_clear  <= job_accept || (state_next == CLEAR);
`ifdef ACCEL_CTRL_SOFTMAX_EN
         softmax_en               <= (state_next == OUT) && softmax_next;
         relu_en                  <= (state_next == OUT) && relu_next && !softmax_next;
`else
         softmax_en               <= 1'b0;
         relu_en                  <= (state_next == OUT) && relu_next;
`endif
         busy                     <= (state_next != IDLE);
         done                     <= (state_next == DONE);
         cfg_err                  <= job_reject;
      end
   end

endmodule
